// File: rtl/adam_spi_slave.sv
// SPI mode-0 slave: synchronizes an external SPI bus into the clk domain and
// exposes single-entry TX holding and RX output registers with valid/ready handshakes.
module adam_spi_slave #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ss_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic                  clr_flags,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  state_e state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] warm_q, warm_d;
  cnt_t  bit_cnt_q, bit_cnt_d;
  word_t tx_shift_q, tx_shift_d;
  word_t rx_shift_q, rx_shift_d;
  word_t hold_q, hold_d;
  logic  hold_full_q, hold_full_d;
  word_t rx_data_q, rx_data_d;
  logic  rx_valid_q, rx_valid_d;
  logic  rx_overrun_q, rx_overrun_d;
  logic  tx_underrun_q, tx_underrun_d;

  logic  sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic  reload, rx_wr, ovr_set, und_set, tx_fire;
  word_t rx_byte;

  // A fall is only trusted once real samples have reached the third stage,
  // so an ss_n held low across reset cannot start a frame.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2] & (warm_q == 2'd3);
  assign rx_byte   = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};

  always_comb begin
    state_d       = state_q;
    sclk_sync_d   = {sclk_sync_q[1:0], spi_sclk_i};
    ss_sync_d     = {ss_sync_q[1:0], spi_ss_n_i};
    mosi_sync_d   = {mosi_sync_q[0], spi_mosi_i};
    warm_d        = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    reload        = 1'b0;
    rx_wr         = 1'b0;
    ovr_set       = 1'b0;
    und_set       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d    = S_ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          reload     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + cnt_t'(1);
          if (bit_cnt_q == cnt_t'(DATA_WIDTH - 1)) begin
            if (!rx_valid_q || rx_ready) rx_wr = 1'b1;
            else ovr_set = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == cnt_t'(DATA_WIDTH)) begin
            reload    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = IDLE_BYTE;
        und_set    = 1'b1;
      end
    end

    // Holding register is only writable when empty, so a same-edge
    // reload always sees the old contents and the new byte stays held.
    tx_fire     = tx_valid & ~hold_full_q;
    hold_full_d = (hold_full_q & ~reload) | tx_fire;
    if (tx_fire) hold_d = tx_data;

    if (rx_wr) begin
      rx_data_d  = rx_byte;
      rx_valid_d = 1'b1;
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end

    rx_overrun_d  = (rx_overrun_q & ~clr_flags) | ovr_set;
    tx_underrun_d = (tx_underrun_q & ~clr_flags) | und_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= 3'b000;
      ss_sync_q     <= 3'b111;
      mosi_sync_q   <= 2'b00;
      warm_q        <= 2'd0;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      warm_q        <= warm_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign spi_miso_o  = tx_shift_q[DATA_WIDTH-1];
  assign spi_miso_oe = (state_q == S_ACTIVE);
  assign busy        = (state_q == S_ACTIVE);
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule
